sequence_generator: RTL and testbench

//  Serial pattern transmitter; the counterpart to the serial sequence detector.

---
 rtl/seqgen_pkg.sv | 21 ++
 rtl/sequence_generator_pattern_shifter.sv | 64 ++++++
 rtl/sequence_generator.sv | 206 ++++++++++++++++++++
 tb/tb_sequence_generator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seqgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seqgen_pkg
//  Purpose  : Shared types and constants for the serial sequence generator.
//             state_t always carries the PARITY encoding so that state
//             registers have the same width in every build.
//  Revision : 1.0 - initial release
// ============================================================================
package seqgen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        GAP    = 2'd2,
        PARITY = 2'd3
    } state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage : seqgen_pkg
`default_nettype wire

// File: rtl/sequence_generator_pattern_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_shifter
//  Purpose  : Load/shift register holding the bit currently on the serial
//             line in its MSB, plus a bit-index counter. o_at_last is a
//             registered flag that is high while bit 0 is in the MSB.
//  Ports    : clk_i, reset_ni  - clock, async active-low reset
//             i_clear          - empty the register (highest priority)
//             i_load, i_data   - load a new word, index = PAT_W-1
//             i_shift          - advance to the next lower bit
//             o_msb            - current serial bit (0 when empty)
//             o_at_last        - current bit is bit 0 of the word
//  Revision : 1.0 - initial release
// ============================================================================
module pattern_shifter #(
    parameter int PAT_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [PAT_W-1:0] i_data,
    output logic             o_msb,
    output logic             o_at_last
);

    localparam int                 c_IDX_W   = $clog2(PAT_W);
    localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(PAT_W - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ZRO = '0;

    logic [PAT_W-1:0]   r_shreg;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_at_last;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_shreg   <= '0;
            r_idx     <= c_IDX_ZRO;
            r_at_last <= 1'b0;
        end else if (i_clear) begin
            r_shreg   <= '0;
            r_idx     <= c_IDX_ZRO;
            r_at_last <= 1'b0;
        end else if (i_load) begin
            r_shreg   <= i_data;
            r_idx     <= c_IDX_TOP;
            r_at_last <= 1'b0;          // PAT_W >= 2, so the MSB is never bit 0
        end else if (i_shift) begin
            r_shreg   <= {r_shreg[PAT_W-2:0], 1'b0};
            // Flag is registered one shift ahead so last_o needs no gating.
            r_at_last <= (r_idx == c_IDX_ONE);
            if (r_idx != c_IDX_ZRO) begin
                r_idx <= r_idx - c_IDX_ONE;
            end
        end
    end

    assign o_msb     = r_shreg[PAT_W-1];
    assign o_at_last = r_at_last;

endmodule : pattern_shifter
`default_nettype wire

// File: rtl/sequence_generator.sv
`default_nettype none
// ============================================================================
//  Module   : sequence_generator
//  Purpose  : Serial pattern transmitter. Sends a PAT_W-bit pattern MSB
//             first, (repeat_i+1) times, with gap_i idle cycles between
//             copies. abort_i returns to IDLE without a done pulse.
//             Optional macro SEQGEN_PARITY_EN appends an even-parity bit
//             after every copy.
//  Ports    : clk_i, reset_ni          - clock, async active-low reset
//             start_i                  - request, taken when ready_o
//             pattern_i/repeat_i/gap_i - configuration sampled on accept
//             abort_i                  - synchronous abort, top priority
//             ready_o                  - high in IDLE only
//             out_o, out_valid_o       - serial bit and its qualifier
//             last_o                   - bit 0 of each copy
//             done_o                   - pulse after the final copy
//  Revision : 1.0 - initial release
// ============================================================================
module sequence_generator
    import seqgen_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [CNT_W-1:0] repeat_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic             out_o,
    output logic             out_valid_o,
    output logic             last_o,
    output logic             done_o
);

    state_t           r_state;
    logic [PAT_W-1:0] r_pattern;
    logic [CNT_W-1:0] r_copies;     // copies still to send after the current one
    logic [GAP_W-1:0] r_gap_cfg;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_valid;
    logic             r_ready;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_copies_nxt;
    logic [GAP_W-1:0] w_gap_cnt_nxt;
    logic             w_valid_nxt;
    logic             w_done_nxt;
    logic             w_latch;
    logic             w_copy_end;
    logic             w_load;
    logic             w_shift;
    logic             w_clear;
    logic [PAT_W-1:0] w_load_data;
    logic             w_msb;
    logic             w_at_last;

    always_comb begin
        w_state_nxt   = r_state;
        w_copies_nxt  = r_copies;
        w_gap_cnt_nxt = r_gap_cnt;
        w_valid_nxt   = r_valid;
        w_done_nxt    = 1'b0;
        w_latch       = 1'b0;
        w_copy_end    = 1'b0;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        w_clear       = 1'b0;
        w_load_data   = r_pattern;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_latch     = 1'b1;
                    w_load      = 1'b1;
                    w_load_data = pattern_i;
                    w_state_nxt = SEND;
                    w_valid_nxt = 1'b1;
                end
            end
            SEND: begin
                if (!w_at_last) begin
                    w_shift = 1'b1;
                end else begin
`ifdef SEQGEN_PARITY_EN
                    // Parity rides in the shifter MSB for one cycle.
                    w_load      = 1'b1;
                    w_load_data = {^r_pattern, {(PAT_W-1){1'b0}}};
                    w_state_nxt = PARITY;
`else
                    w_copy_end  = 1'b1;
`endif
                end
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            PARITY: begin
`ifdef SEQGEN_PARITY_EN
                w_copy_end  = 1'b1;
`else
                w_clear     = 1'b1;
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
`endif
            end
            default: begin
                w_clear     = 1'b1;
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase

        // End of one copy: finish, start next copy directly, or idle gap.
        if (w_copy_end) begin
            if (r_copies == '0) begin
                w_clear     = 1'b1;
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
                w_done_nxt  = 1'b1;
            end else begin
                w_copies_nxt = r_copies - CNT_W'(1);
                if (r_gap_cfg == '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_clear       = 1'b1;
                    w_state_nxt   = GAP;
                    w_valid_nxt   = 1'b0;
                    w_gap_cnt_nxt = r_gap_cfg - GAP_W'(1);
                end
            end
        end

        // Abort overrides everything, including a simultaneous start.
        if (abort_i) begin
            w_latch     = 1'b0;
            w_load      = 1'b0;
            w_shift     = 1'b0;
            w_clear     = 1'b1;
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= IDLE;
            r_pattern <= '0;
            r_copies  <= '0;
            r_gap_cfg <= '0;
            r_gap_cnt <= '0;
            r_valid   <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_ready   <= (w_state_nxt == IDLE);
            r_done    <= w_done_nxt;
            if (w_latch) begin
                r_pattern <= pattern_i;
                r_copies  <= repeat_i;
                r_gap_cfg <= gap_i;
            end else begin
                r_copies  <= w_copies_nxt;
            end
        end
    end

    pattern_shifter #(
        .PAT_W (PAT_W)
    ) u_shifter (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .i_clear   (w_clear),
        .i_load    (w_load),
        .i_shift   (w_shift),
        .i_data    (w_load_data),
        .o_msb     (w_msb),
        .o_at_last (w_at_last)
    );

    // Shifter is emptied whenever nothing is being sent, so its MSB is 0 then.
    assign out_o       = w_msb;
    assign last_o      = w_at_last;
    assign out_valid_o = r_valid;
    assign ready_o     = r_ready;
    assign done_o      = r_done;

endmodule : sequence_generator
`default_nettype wire

// File: tb/tb_sequence_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sequence_generator
//  Purpose  : Directed self-checking bench for sequence_generator.
//             Output vector compared each cycle is
//             {ready_o, out_valid_o, out_o, last_o, done_o}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sequence_generator;
    import seqgen_pkg::*;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic       start_i;
    logic [3:0] pattern_i;
    logic [7:0] repeat_i;
    logic [3:0] gap_i;
    logic       abort_i;
    logic       ready_o;
    logic       out_o;
    logic       out_valid_o;
    logic       last_o;
    logic       done_o;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] hist;
    int         dets;
    logic [4:0] t_copy [4];

    always #5 clk_i = ~clk_i;

    sequence_generator #(
        .PAT_W (4),
        .CNT_W (8),
        .GAP_W (4)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .start_i     (start_i),
        .pattern_i   (pattern_i),
        .repeat_i    (repeat_i),
        .gap_i       (gap_i),
        .abort_i     (abort_i),
        .ready_o     (ready_o),
        .out_o       (out_o),
        .out_valid_o (out_valid_o),
        .last_o      (last_o),
        .done_o      (done_o)
    );

    function automatic logic [4:0] outs();
        return {ready_o, out_valid_o, out_o, last_o, done_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, check outputs, feed a 1011 detector with valid bits.
    task automatic step(input string tag, input logic [4:0] exp);
        @(negedge clk_i);
        chk(tag, {27'd0, outs()}, {27'd0, exp});
        if (out_valid_o === 1'b1) begin
            hist = {hist[2:0], out_o};
            if (hist == 4'b1011) dets++;
        end
    endtask

    initial begin
        int nbits;
        int nlast;
        int ndone;

        t_copy[0] = 5'b01100;
        t_copy[1] = 5'b01000;
        t_copy[2] = 5'b01100;
        t_copy[3] = 5'b01110;

        reset_ni = 1'b0; start_i = 1'b0; pattern_i = '0;
        repeat_i = '0;   gap_i = '0;     abort_i = 1'b0;
        hist = '0; dets = 0;
        repeat (2) @(negedge clk_i);
        chk("reset_state", {27'd0, outs()}, 32'h10);
        reset_ni = 1'b1;
        step("idle_after_reset", 5'b10000);

`ifdef SEQGEN_PARITY_EN
        // Single copy with even-parity bit (^1011 = 1)
        start_i = 1'b1; pattern_i = DEFAULT_PATTERN; repeat_i = 8'd0; gap_i = 4'd0;
        step("par_b1", 5'b01100);
        start_i = 1'b0;
        step("par_b2", 5'b01000);
        step("par_b3", 5'b01100);
        step("par_b4", 5'b01110);
        step("par_p",  5'b01100);
        step("par_done", 5'b10001);
        step("par_idle", 5'b10000);
`else
        // Single copy: 1,0,1,1 then done
        hist = '0; dets = 0;
        start_i = 1'b1; pattern_i = DEFAULT_PATTERN; repeat_i = 8'd0; gap_i = 4'd0;
        step("t2_b1", 5'b01100);
        start_i = 1'b0;
        step("t2_b2", 5'b01000);
        step("t2_b3", 5'b01100);
        step("t2_b4", 5'b01110);
        step("t2_done", 5'b10001);
        step("t2_idle", 5'b10000);
        chk("t2_dets", dets, 1);

        // Three copies back-to-back
        hist = '0; dets = 0;
        start_i = 1'b1; repeat_i = 8'd2; gap_i = 4'd0;
        for (int c = 0; c < 3; c++) begin
            for (int b = 0; b < 4; b++) begin
                step($sformatf("t3_c%0d_b%0d", c, b), t_copy[b]);
                start_i = 1'b0;
            end
        end
        step("t3_done", 5'b10001);
        chk("t3_dets", dets, 3);

        // Two copies with a 3-cycle gap
        hist = '0; dets = 0;
        start_i = 1'b1; repeat_i = 8'd1; gap_i = 4'd3;
        for (int b = 0; b < 4; b++) begin
            step($sformatf("t4_c0_b%0d", b), t_copy[b]);
            start_i = 1'b0;
        end
        for (int g = 0; g < 3; g++) step($sformatf("t4_gap%0d", g), 5'b00000);
        for (int b = 0; b < 4; b++) step($sformatf("t4_c1_b%0d", b), t_copy[b]);
        step("t4_done", 5'b10001);
        chk("t4_dets", dets, 2);

        // Maximum repeat count: 256 copies, no wrap
        nbits = 0; nlast = 0; ndone = 0;
        start_i = 1'b1; repeat_i = 8'hFF; gap_i = 4'd0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (out_valid_o === 1'b1) nbits++;
            if (last_o === 1'b1) nlast++;
            if (done_o === 1'b1) begin
                ndone++;
                break;
            end
        end
        chk("max_bits", nbits, 1024);
        chk("max_last", nlast, 256);
        chk("max_done", ndone, 1);
        chk("max_ready", {31'd0, ready_o}, 1);
`endif

        // Abort on 2nd bit with a busy start
        start_i = 1'b1; pattern_i = 4'b1011; repeat_i = 8'd0; gap_i = 4'd0;
        step("t5_b1", 5'b01100);
        pattern_i = 4'b1111; repeat_i = 8'd5;     // start_i still high while busy
        step("t5_b2", 5'b01000);
        start_i = 1'b0; abort_i = 1'b1;
        step("t5_abort", 5'b10000);
        abort_i = 1'b0;
        step("t5_nodone", 5'b10000);
        start_i = 1'b1; abort_i = 1'b1;
        step("t5_abort_start", 5'b10000);
        start_i = 1'b0; abort_i = 1'b0;
        step("t5_idle", 5'b10000);

        // Asynchronous reset mid-transmission
        start_i = 1'b1; pattern_i = 4'b1011; repeat_i = 8'd3; gap_i = 4'd0;
        step("t1_b1", 5'b01100);
        start_i = 1'b0;
        step("t1_b2", 5'b01000);
        #2 reset_ni = 1'b0;
        #1 chk("t1_async_rst", {27'd0, outs()}, 32'h10);
        @(negedge clk_i);
        reset_ni = 1'b1;
        step("t1_idle1", 5'b10000);
        step("t1_idle2", 5'b10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sequence_generator
`default_nettype wire
